// File: rtl/blocks_fifo.sv
// -----------------------------------------------------------------------------
// blocks_fifo
//   Block-stream buffer between the JPEG block producer and the HDMI output
//   formatter. Each word carries CH colour channels x N signed byte lanes plus
//   eob/sob/sof flags. Words live in an inferred dual-port RAM. The RAM's
//   registered read port is also the show-ahead output register, so total
//   capacity is DEPTH+1 words.
//
//   Input side: DROP_MODE=0 applies backpressure through in_ready.
//   DROP_MODE=1 always accepts. On overflow it drops the rest of the current
//   frame and resynchronises on the next start-of-frame word that fits.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         input handshake
//   in_data                   ch c lane l at [(c*N+l)*8 +: 8]
//   in_eob/in_sob/in_sof      end/start of block, start of frame
//   out_valid/out_ready       show-ahead output handshake
//   out_data, out_eob/sob/sof head word and its flags
//   level                     words held (RAM + output register)
//   almost_full               level >= AF_LVL
//   overflow, drop_cnt        sticky drop flag, saturating drop counter
//   clr_ovf                   synchronous clear of overflow/drop_cnt
// -----------------------------------------------------------------------------
module blocks_fifo #(
  parameter int N         = 2,
  parameter int CH        = 3,
  parameter int DEPTH     = 1024,
  parameter int AF_LVL    = 768,
  parameter int DROP_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH*N*8-1:0]           in_data,
  input  logic                        in_eob,
  input  logic                        in_sob,
  input  logic                        in_sof,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH*N*8-1:0]           out_data,
  output logic                        out_eob,
  output logic                        out_sob,
  output logic                        out_sof,
  output logic [$clog2(DEPTH+2)-1:0]  level,
  output logic                        almost_full,
  output logic                        overflow,
  input  logic                        clr_ovf,
  output logic [15:0]                 drop_cnt
);

  localparam int DW = CH*N*8;
  localparam int WW = DW + 3;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+2);

  typedef enum logic {ACCEPT, DROPPING} state_t;

  state_t          state, state_nxt;
  logic            full, wr_en, rd_en, xfer, drop;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   ram_cnt;
  logic [WW-1:0]   mem [DEPTH];
  logic [WW-1:0]   out_word;

  // Pointer wrap is explicit so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // full comes from the registered level, so a same-cycle read never frees
  // a slot for a same-cycle write.
  assign full        = (level == LW'(DEPTH+1));
  assign almost_full = (32'(level) >= AF_LVL);
  assign xfer        = out_valid && out_ready;
  // Prefetch only words already counted in ram_cnt, i.e. written on an
  // earlier edge, so a read never targets the address being written.
  assign rd_en       = (ram_cnt != '0) && (!out_valid || out_ready);
  assign in_ready    = (DROP_MODE != 0) ? 1'b1 : (!full && !rst);

  assign out_data = out_word[DW-1:0];
  assign out_eob  = out_word[DW];
  assign out_sob  = out_word[DW+1];
  assign out_sof  = out_word[DW+2];

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    drop      = 1'b0;
    if (DROP_MODE == 0) begin
      wr_en = in_valid && !full;
    end else begin
      case (state)
        ACCEPT: begin
          if (in_valid) begin
            if (!full) begin
              wr_en = 1'b1;
            end else begin
              drop      = 1'b1;
              state_nxt = DROPPING;
            end
          end
        end
        DROPPING: begin
          if (in_valid) begin
            if (in_sof && !full) begin
              wr_en     = 1'b1;
              state_nxt = ACCEPT;
            end else begin
              drop = 1'b1;
            end
          end
        end
        default: state_nxt = ACCEPT;
      endcase
    end
  end

  // Stage boundary: RAM write (storage array carries no reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_sof, in_sob, in_eob, in_data};
  end

  // Stage boundary: RAM read register doubling as the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCEPT;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);

      case ({wr_en, rd_en})
        2'b10:   ram_cnt <= ram_cnt + LW'(1);
        2'b01:   ram_cnt <= ram_cnt - LW'(1);
        default: ram_cnt <= ram_cnt;
      endcase

      case ({wr_en, xfer})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (rd_en) begin
        out_word  <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end

      // A drop in the same cycle as clr_ovf wins: the counter restarts at 1.
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= clr_ovf ? 16'd1 : sat_inc16(drop_cnt);
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule
